// File: rtl/vehicle_pkg.sv
// Shared gear codes, reject reasons and shift FSM state for the vehicle model.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package vehicle_pkg;

   // Selector codes presented to the physics block.
   localparam logic [3:0] GEAR_P = 4'd3;
   localparam logic [3:0] GEAR_R = 4'd6;
   localparam logic [3:0] GEAR_N = 4'd9;
   localparam logic [3:0] GEAR_D = 4'd12;

   // Reason reported alongside shift_reject.
   localparam logic [1:0] REJ_BAD_GEAR = 2'd0;
   localparam logic [1:0] REJ_NO_BRAKE = 2'd1;
   localparam logic [1:0] REJ_SPEED    = 2'd2;
   localparam logic [1:0] REJ_ENGINE   = 2'd3;

   // Gear ceiling outside low-gear mode, and the low-gear limit range.
   localparam logic [2:0] LIMIT_FULL    = 3'd6;
   localparam logic [2:0] LIMIT_LOW_MIN = 3'd1;
   localparam logic [2:0] LIMIT_LOW_MAX = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_HOLD  = 2'd2
   } shift_state_t;

   function automatic logic is_valid_gear(input logic [3:0] g);
      return (g == GEAR_P) || (g == GEAR_R) || (g == GEAR_N) || (g == GEAR_D);
   endfunction

endpackage

// File: rtl/shift_timer.sv
// Counts tick pulses while a shift sits in neutral; flags the terminal tick.
// Latency: tc is combinational on the tick that completes TICKS counts.
// Backpressure: none; clr overrides counting.
// Ports: clk, rst (async, active high), clr (hold count at zero),
//        tick (one-cycle physics tick), tc (terminal-count tick).
module shift_timer #(
   parameter int unsigned TICKS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic tick,
   output logic tc
);

   logic [3:0] count;

   // tc fires on the tick that would make the count reach TICKS, so the
   // caller can act on that same edge.
   assign tc = !clr && tick && (count == 4'(TICKS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 4'd0;
      end else if (clr) begin
         count <= 4'd0;
      end else if (tick) begin
         count <= count + 4'd1;
      end
   end

endmodule

// File: rtl/gear_shift_controller.sv
// Transmission selector: interlock-checked gear requests with a timed neutral phase.
// Latency: reject/same-gear done 1 cycle after accept; full shift ends on the SHIFT_TICKS-th tick in HOLD.
// Backpressure: shift_req_ready is high only in IDLE; requester holds valid until accepted.
// Ports: clk, rst; engine_on, tick_speed, speed, is_brake_normal, is_brake_hard;
//        shift_req_valid/ready/gear handshake; low_gear_toggle/up/down and
//        side_brake_toggle pulses; current_gear, shift_busy, shift_done,
//        shift_reject, reject_code, is_low_gear_mode, max_gear_limit, is_side_brake.
// Build option: define GEAR_AUTO_PARK_EN to drop into P with the side brake
// applied when the engine stops at standstill in IDLE.
module gear_shift_controller
   import vehicle_pkg::*;
#(
   parameter int unsigned SHIFT_TICKS      = 4,
   parameter int unsigned STOP_SPEED_MAX   = 3,
   parameter int unsigned LOW_GEAR_DEFAULT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       engine_on,
   input  logic       tick_speed,
   input  logic [7:0] speed,
   input  logic       is_brake_normal,
   input  logic       is_brake_hard,
   input  logic       shift_req_valid,
   input  logic [3:0] shift_req_gear,
   output logic       shift_req_ready,
   input  logic       low_gear_toggle,
   input  logic       low_gear_up,
   input  logic       low_gear_down,
   input  logic       side_brake_toggle,
   output logic [3:0] current_gear,
   output logic       shift_busy,
   output logic       shift_done,
   output logic       shift_reject,
   output logic [1:0] reject_code,
   output logic       is_low_gear_mode,
   output logic [2:0] max_gear_limit,
   output logic       is_side_brake
);

   shift_state_t state_q, state_d;
   logic [3:0]   target_q;
   logic         accept;
   logic         stopped;
   logic         brake_any;
   logic         hold_tc;
   logic         chk_reject;
   logic [1:0]   chk_code;
   logic         chk_same;

   assign accept    = (state_q == ST_IDLE) && shift_req_valid;
   assign stopped   = (speed <= 8'(STOP_SPEED_MAX));
   assign brake_any = is_brake_normal || is_brake_hard;
   assign chk_same  = (target_q == current_gear);

   shift_timer #(.TICKS(SHIFT_TICKS)) u_shift_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_q != ST_HOLD),
      .tick (tick_speed),
      .tc   (hold_tc)
   );

   // Interlocks in priority order; the first failing rule names the reason.
   always_comb begin
      chk_reject = 1'b1;
      chk_code   = REJ_BAD_GEAR;
      if (!is_valid_gear(target_q)) begin
         chk_code = REJ_BAD_GEAR;
      end else if (!engine_on) begin
         chk_code = REJ_ENGINE;
      end else if ((current_gear == GEAR_P) && !brake_any) begin
         chk_code = REJ_NO_BRAKE;
      end else if (!stopped && ((target_q == GEAR_P) || (target_q == GEAR_R) ||
                                ((current_gear == GEAR_R) && (target_q == GEAR_D)))) begin
         // D->R is already covered by the target-R term.
         chk_code = REJ_SPEED;
      end else begin
         chk_reject = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (shift_req_valid) state_d = ST_CHECK;
         ST_CHECK: state_d = (chk_reject || chk_same) ? ST_IDLE : ST_HOLD;
         ST_HOLD:  if (!engine_on || hold_tc) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output logic (the only combinational output)
   always_comb begin
      shift_req_ready = (state_q == ST_IDLE);
   end

`ifdef GEAR_AUTO_PARK_EN
   logic engine_on_q;
`endif

   // Registered outputs and datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         target_q         <= GEAR_P;
         current_gear     <= GEAR_P;
         shift_busy       <= 1'b0;
         shift_done       <= 1'b0;
         shift_reject     <= 1'b0;
         reject_code      <= REJ_BAD_GEAR;
         is_low_gear_mode <= 1'b0;
         max_gear_limit   <= LIMIT_FULL;
         is_side_brake    <= 1'b1;
`ifdef GEAR_AUTO_PARK_EN
         engine_on_q      <= 1'b0;
`endif
      end else begin
         shift_done   <= 1'b0;
         shift_reject <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  // Low-gear pulses on the accept edge are dropped.
                  target_q <= shift_req_gear;
               end else if (current_gear == GEAR_D) begin
                  if (low_gear_toggle) begin
                     is_low_gear_mode <= !is_low_gear_mode;
                     max_gear_limit   <= is_low_gear_mode ? LIMIT_FULL : 3'(LOW_GEAR_DEFAULT);
                  end else if (is_low_gear_mode && low_gear_up) begin
                     if (max_gear_limit < LIMIT_LOW_MAX) max_gear_limit <= max_gear_limit + 3'd1;
                  end else if (is_low_gear_mode && low_gear_down) begin
                     if (max_gear_limit > LIMIT_LOW_MIN) max_gear_limit <= max_gear_limit - 3'd1;
                  end
               end
            end
            ST_CHECK: begin
               if (chk_reject) begin
                  shift_reject <= 1'b1;
                  reject_code  <= chk_code;
               end else if (chk_same) begin
                  shift_done <= 1'b1;
               end else begin
                  current_gear <= GEAR_N;
                  shift_busy   <= 1'b1;
                  // Target differs from current here, so leaving D is certain.
                  if (current_gear == GEAR_D) begin
                     is_low_gear_mode <= 1'b0;
                     max_gear_limit   <= LIMIT_FULL;
                  end
               end
            end
            ST_HOLD: begin
               if (!engine_on) begin
                  // Abort: stay in neutral, no completion pulse.
                  shift_busy <= 1'b0;
               end else if (hold_tc) begin
                  current_gear <= target_q;
                  shift_busy   <= 1'b0;
                  shift_done   <= 1'b1;
               end
            end
            default: ;
         endcase

         if (side_brake_toggle) begin
            if (is_side_brake) begin
               if (brake_any && engine_on) is_side_brake <= 1'b0;
            end else if (stopped) begin
               is_side_brake <= 1'b1;
            end
         end

`ifdef GEAR_AUTO_PARK_EN
         engine_on_q <= engine_on;
         if ((state_q == ST_IDLE) && engine_on_q && !engine_on &&
             (current_gear != GEAR_P) && stopped) begin
            current_gear     <= GEAR_P;
            is_side_brake    <= 1'b1;
            is_low_gear_mode <= 1'b0;
            max_gear_limit   <= LIMIT_FULL;
         end
`endif
      end
   end

endmodule

// File: doc/gear_shift_controller.md
# gear_shift_controller

Sequences the automatic transmission selector for the vehicle model. Accepts gear-change requests from the driver-input layer and applies brake/speed/engine interlocks. Passes every accepted change through a timed neutral phase and drives the `current_gear`, `is_low_gear_mode`, `max_gear_limit` and `is_side_brake` inputs of the vehicle physics block. Sits between the button/ADC front end and the physics datapath.

## Interface
- `SHIFT_TICKS`, 4: `tick_speed` pulses spent in neutral during a shift (range 1–15).
- `STOP_SPEED_MAX`, 3: highest `speed` (km/h) treated as stopped for P/R entry, D↔R reversal and side-brake apply.
- `LOW_GEAR_DEFAULT`, 3: `max_gear_limit` loaded on entering low-gear mode (range 1–3).

Ports (`name direction width meaning`):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `engine_on` in 1: engine running.
- `tick_speed` in 1: one-cycle physics tick.
- `speed` in 8: current speed, km/h.
- `is_brake_normal` in 1: normal brake pedal.
- `is_brake_hard` in 1: hard brake pedal.
- `shift_req_valid` in 1: gear request valid.
- `shift_req_gear` in 4: requested gear (3 = P, 6 = R, 9 = N, 12 = D).
- `shift_req_ready` out 1: high only in IDLE.
- `low_gear_toggle` in 1: pulse, toggle low-gear mode.
- `low_gear_up` in 1: pulse, raise the limit.
- `low_gear_down` in 1: pulse, lower the limit.
- `side_brake_toggle` in 1: pulse, apply or release the side brake.
- `current_gear` out 4: gear presented to physics.
- `shift_busy` out 1: shift in progress.
- `shift_done` out 1: one-cycle pulse, shift complete.
- `shift_reject` out 1: one-cycle pulse, request refused.
- `reject_code` out 2: reason, valid while `shift_reject` is high.
- `is_low_gear_mode` out 1: low-gear mode active.
- `max_gear_limit` out 3: gear ceiling.
- `is_side_brake` out 1: side brake applied.

## Operation
- **Reset values:**
  - `current_gear` = 3 (P)
  - `is_side_brake` = 1; `max_gear_limit` = 6
  - `shift_req_ready` = 1
  - all other outputs = 0
  - FSM in IDLE
- **Handshake:** a request is accepted on an edge with `shift_req_valid && shift_req_ready`. `shift_req_gear` is captured as the target. The requester holds valid until ready.
- **FSM states:** IDLE, CHECK, HOLD.
- **IDLE → CHECK** on accept.
- **CHECK** evaluates the rules below in priority order. On reject: pulse `shift_reject` with `reject_code`, return to IDLE, gear unchanged.
  - 0: `shift_req_gear` is not one of 3/6/9/12.
  - 3: `!engine_on`.
  - 1: current gear is P and neither brake is pressed.
  - 2: target is P or R and `speed > STOP_SPEED_MAX`; also D→R or R→D with `speed > STOP_SPEED_MAX`.
- **CHECK, target equals current gear:** pulse `shift_done`, go to IDLE, no neutral phase.
- **CHECK, pass:** `current_gear` ← 9, `shift_busy` ← 1, timer cleared, go to HOLD.
- **HOLD:** counts `tick_speed` pulses. On the `SHIFT_TICKS`-th tick: `current_gear` ← target, `shift_busy` ← 0, `shift_done` pulses, go to IDLE.
- **Low-gear mode:**
  - Low-gear pulses act only in IDLE with `current_gear` = 12; otherwise they are ignored.
  - `low_gear_toggle` entering the mode: `is_low_gear_mode` ← 1, limit ← `LOW_GEAR_DEFAULT`.
  - `low_gear_toggle` leaving the mode: `is_low_gear_mode` ← 0, limit ← 6.
  - up/down change the limit by 1, saturating at 1 and 3.
  - Any accepted shift away from D clears the mode and sets the limit to 6.
- **Side brake:**
  - Apply is allowed when `speed <= STOP_SPEED_MAX`.
  - Release requires a brake pedal and `engine_on`.
  - A disallowed toggle is ignored silently. Toggles are honoured in any FSM state.
- **Simultaneous events:**
  - Accept has priority over low-gear pulses on the same edge; those pulses are dropped.
  - Multiple low-gear pulses on one edge: toggle > up > down.
- **Engine off:**
  - In HOLD: abort to IDLE, `current_gear` stays 9, no `shift_done`.
  - In CHECK: resolves as reject code 3.

## Timing
- Reject or same-gear completion: pulse is high in the cycle after accept (1-cycle latency).
- Full shift: `current_gear` reads 9 from accept+1 until the edge of the `SHIFT_TICKS`-th `tick_speed` after entering HOLD. A tick on the CHECK edge is not counted.
- `shift_req_ready` is low from accept+0 until the IDLE return.
- All outputs are registered; no combinational input→output paths except `shift_req_ready` from state.

## Configuration
- `GEAR_AUTO_PARK_EN` defined:
  - Trigger: in IDLE, a falling edge of `engine_on` with `current_gear` ≠ 3 and `speed <= STOP_SPEED_MAX`.
  - Response: `current_gear` ← 3 and `is_side_brake` ← 1 on the next edge, with no neutral phase and no `shift_done`.
- Undefined: the gear is left unchanged at engine off.

## Structure
- Shared package `vehicle_pkg`:
  - gear code constants `GEAR_P`/`GEAR_R`/`GEAR_N`/`GEAR_D`
  - reject code constants
  - FSM state typedef
- Sub-module `shift_timer`: 4-bit `tick_speed` counter with clear and terminal-count output, instantiated once.

## Test plan
- Reset, then request 12 with `is_brake_normal` = 1 and `speed` = 0 → `current_gear` = 9 for 4 ticks, then 12, with one `shift_done` pulse.
- From P, request 12 with no brake → `shift_reject`, `reject_code` = 1, gear stays 3.
- In D at `speed` = 40, request 6 → reject code 2. At `speed` = 2 → accepted, ends at 6.
- In D: `low_gear_toggle`, then `low_gear_up` ×3 → limit 3, then 3, then 3. `low_gear_down` ×4 → 2, 1, 1, 1. Shift to N → mode 0, limit 6.
- Drop `engine_on` in HOLD → IDLE with gear 9 and no done pulse. With `GEAR_AUTO_PARK_EN` at `speed` = 0 in D, drop `engine_on` → gear 3, side brake 1.
- Assert `rst` mid-HOLD → all outputs at reset values immediately, with no clock edge required.
